// File: rtl/bist_pkg.sv
// Shared encodings for the gate BIST engine: gate op codes, FSM states, default MISR polynomial, Gray helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bist_pkg;

  // Gate operation encoding; codes 5..7 fall back to NAND in the gate model
  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_NOR  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;

  // Widest supported gate; the Gray helper works at this width and callers truncate
  localparam int GRAY_W = 12;

  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] DEFAULT_POLY = 16'h1021;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [GRAY_W-1:0] gray(input logic [GRAY_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

endpackage

// File: rtl/gut_gate.sv
// Gate-under-test: W-input NAND/AND/NOR/OR/XOR with optional single stuck-at on one input or the output.
// Latency: purely combinational.
// Backpressure: none.
module gut_gate
  import bist_pkg::*;
#(
  parameter int W = 2,
  localparam int FW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in,
  input  logic [2:0]    op,
  input  logic          fault_en,
  input  logic [FW-1:0] fault_site,
  input  logic          fault_val,
  output logic          out
);

  logic [W-1:0] gin;
  logic         res;

  // Apply the input-site fault, evaluate the gate, then apply the output-site fault
  always_comb begin
    gin = in;
    for (int i = 0; i < W; i++) begin
      if (fault_en && (fault_site == FW'(i))) begin
        gin[i] = fault_val;
      end
    end
    case (op)
      OP_AND:  res = &gin;
      OP_NOR:  res = ~|gin;
      OP_OR:   res = |gin;
      OP_XOR:  res = ^gin;
      default: res = ~&gin;
    endcase
    out = (fault_en && (fault_site == FW'(W))) ? fault_val : res;
  end

endmodule

// File: rtl/bist_gate_tester.sv
// BIST engine: drives 2^W binary or Gray patterns into one gate and compacts its response in a serial MISR.
// Latency: done rises N=2^W cycles after the start edge, no dead cycles between patterns.
// Backpressure: none; start is a one-cycle request honoured in IDLE or DONE and ignored while running.
module bist_gate_tester
  import bist_pkg::*;
#(
  parameter int W = 2,
  parameter int SW = 16,
  parameter logic [SW-1:0] POLY = SW'(DEFAULT_POLY),
  localparam int FW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    gate_op,
  input  logic          pat_mode,
  input  logic          fault_en,
  input  logic [FW-1:0] fault_site,
  input  logic          fault_val,
  input  logic [SW-1:0] exp_sig,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [W-1:0]  pat_out,
  output logic          gut_out,
  output logic [SW-1:0] signature
);

  // One spare counter bit so the count past the last pattern never aliases pattern 0
  localparam int CW = W + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << W) - 1);

  state_t        state, state_nxt;
  logic          accept;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sig, sig_nxt;
  logic          fb;

  // Configuration captured at the accepted start so mid-run input changes are inert
  logic [2:0]    op_q;
  logic          mode_q;
  logic          fen_q;
  logic [FW-1:0] site_q;
  logic          fval_q;
  logic [SW-1:0] exp_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state, start acceptance and status flags
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Config latch, pattern counter and MISR; start clears, each RUN cycle absorbs one gate response
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_NAND;
      mode_q <= 1'b0;
      fen_q  <= 1'b0;
      site_q <= '0;
      fval_q <= 1'b0;
      exp_q  <= '0;
      cnt    <= '0;
      sig    <= '0;
    end else if (accept) begin
      op_q   <= gate_op;
      mode_q <= pat_mode;
      fen_q  <= fault_en;
      site_q <= fault_site;
      fval_q <= fault_val;
      exp_q  <= exp_sig;
      cnt    <= '0;
      sig    <= '0;
    end else if (busy) begin
      cnt <= cnt + CW'(1);
      sig <= sig_nxt;
    end
  end

  assign pat_out = mode_q ? W'(gray(GRAY_W'(cnt[W-1:0]))) : cnt[W-1:0];

  gut_gate #(.W(W)) u_gut (
    .in         (pat_out),
    .op         (op_q),
    .fault_en   (fen_q),
    .fault_site (site_q),
    .fault_val  (fval_q),
    .out        (gut_out)
  );

  // Serial-input MISR step: shift left, fold in POLY when MSB xor response is set
  always_comb begin
    fb      = sig[SW-1] ^ gut_out;
    sig_nxt = {sig[SW-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  assign signature = sig;
  assign pass      = done && (sig == exp_q);

endmodule
